uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo_if.sv | 10 +
 rtl/uart_rx_fifo.sv | 107 ++++++++++
 tb/tb_uart_rx_fifo.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Consumer-side byte stream of uart_rx_fifo: valid/ready with first-word fall-through data.
// master = the FIFO presenting bytes, slave = the consumer accepting them.
interface uart_rx_fifo_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive buffer between buart and byte consumers: drains buart with a valid/rd strobe and
// presents bytes on a FWFT valid/ready stream. Optional statistics: define UART_RX_FIFO_STATS_EN.
module uart_rx_fifo #(
    parameter int DEPTH        = 16,
    parameter bit DROP_ON_FULL = 1'b1,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk,
    input  logic          resetq,
    input  logic          uart_valid,
    input  logic [7:0]    uart_rx_data,
    output logic          uart_rd,
    uart_rx_fifo_if.master m,
    output logic [LW-1:0] level,
    output logic          overflow,
    input  logic          ovf_clr
`ifdef UART_RX_FIFO_STATS_EN
    ,
    output logic [15:0]   drop_count,
    output logic [LW-1:0] max_level
`endif
);

    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

    state_t        state, state_nxt;
    logic          push, drop, pop, full;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    assign full      = (level == LW'(DEPTH));
    assign m.m_valid = (level != '0);
    assign m.m_data  = mem[rd_ptr];
    assign pop       = m.m_valid && m.m_ready;
    // Decoded from the state register so an async reset drops the strobe at once.
    assign uart_rd   = (state == ACK);

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) state <= IDLE;
        else         state <= state_nxt;
    end

    // HOLD masks the stale uart_valid while buart reacts to the rd strobe.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (uart_valid) begin
                    if (!full) begin
                        push      = 1'b1;
                        state_nxt = ACK;
                    end else if (DROP_ON_FULL) begin
                        drop      = 1'b1;
                        state_nxt = ACK;
                    end
                end
            end
            ACK:     state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= uart_rx_data;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_STATS_EN
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            drop_count <= '0;
            max_level  <= '0;
        end else begin
            if (drop) begin
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
            end else if (ovf_clr) begin
                drop_count <= '0;
            end
            if (ovf_clr)                max_level <= '0;
            else if (level > max_level) max_level <= level;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: DUT 0 built with DROP_ON_FULL=1, DUT 1 with DROP_ON_FULL=0.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       resetq;
    logic       valid   [2];
    logic [7:0] rxd     [2];
    logic       rd      [2];
    logic       ready   [2];
    logic       ovf_clr [2];
    logic       ovf     [2];
    logic [4:0] level   [2];
    logic [7:0] mdata   [2];
    logic       mvalid  [2];
    int         rd_cnt  [2];
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    uart_rx_fifo_if s0 ();
    uart_rx_fifo_if s1 ();

    assign s0.m_ready = ready[0];
    assign s1.m_ready = ready[1];
    assign mdata[0]   = s0.m_data;
    assign mdata[1]   = s1.m_data;
    assign mvalid[0]  = s0.m_valid;
    assign mvalid[1]  = s1.m_valid;

`ifdef UART_RX_FIFO_STATS_EN
    logic [15:0] dcnt [2];
    logic [4:0]  mlvl [2];
`endif

    uart_rx_fifo #(.DEPTH(16), .DROP_ON_FULL(1'b1)) dut_drop (
        .clk(clk), .resetq(resetq), .uart_valid(valid[0]), .uart_rx_data(rxd[0]),
        .uart_rd(rd[0]), .m(s0), .level(level[0]), .overflow(ovf[0]), .ovf_clr(ovf_clr[0])
`ifdef UART_RX_FIFO_STATS_EN
        , .drop_count(dcnt[0]), .max_level(mlvl[0])
`endif
    );

    uart_rx_fifo #(.DEPTH(16), .DROP_ON_FULL(1'b0)) dut_bp (
        .clk(clk), .resetq(resetq), .uart_valid(valid[1]), .uart_rx_data(rxd[1]),
        .uart_rd(rd[1]), .m(s1), .level(level[1]), .overflow(ovf[1]), .ovf_clr(ovf_clr[1])
`ifdef UART_RX_FIFO_STATS_EN
        , .drop_count(dcnt[1]), .max_level(mlvl[1])
`endif
    );

    initial begin
        rd_cnt[0] = 0;
        rd_cnt[1] = 0;
    end

    always @(posedge clk) begin
        if (rd[0]) rd_cnt[0] <= rd_cnt[0] + 1;
        if (rd[1]) rd_cnt[1] <= rd_cnt[1] + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Acts as buart: hold valid until the rd strobe is seen, then drop it. Returns in HOLD.
    task automatic send(input int s, input logic [7:0] b);
        bit got = 1'b0;
        valid[s] = 1'b1;
        rxd[s]   = b;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rd[s]) got = 1'b1;
        end
        valid[s] = 1'b0;
        chk("send_rd_seen", 32'(got), 32'd1);
        @(negedge clk);
    endtask

    task automatic pop(input int s, output logic [7:0] d);
        d        = mdata[s];
        ready[s] = 1'b1;
        @(negedge clk);
        ready[s] = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        int         c0;
        int         max_lvl;
        bit         got;

        resetq = 1'b0;
        for (int s = 0; s < 2; s++) begin
            valid[s] = 1'b0; rxd[s] = 8'h00; ready[s] = 1'b0; ovf_clr[s] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_rd",     32'(rd[0]),     32'd0);
        chk("rst_mvalid", 32'(mvalid[0]), 32'd0);
        chk("rst_level",  32'(level[0]),  32'd0);
        chk("rst_ovf",    32'(ovf[0]),    32'd0);
        chk("rst_level1", 32'(level[1]),  32'd0);
        resetq = 1'b1;
        @(negedge clk);

        // Single byte
        valid[0] = 1'b1; rxd[0] = 8'h41;
        @(negedge clk);
        chk("single_rd",     32'(rd[0]),     32'd1);
        chk("single_mvalid", 32'(mvalid[0]), 32'd1);
        chk("single_data",   32'(mdata[0]),  32'h41);
        chk("single_level",  32'(level[0]),  32'd1);
        valid[0] = 1'b0;
        @(negedge clk);
        chk("single_rd_width", 32'(rd[0]), 32'd0);
        pop(0, d);
        chk("single_pop", 32'(d), 32'h41);
        chk("single_lvl0", 32'(level[0]), 32'd0);

        // Ordering and pointer wrap with an eager consumer
        max_lvl = 0;
        for (int i = 0; i < 20; i++) begin
            send(0, 8'(i));
            if (int'(level[0]) > max_lvl) max_lvl = int'(level[0]);
            pop(0, d);
            chk("order_data", 32'(d), 32'(i));
        end
        chk("order_maxlvl", 32'(max_lvl), 32'd1);

        // Fill with drop-on-full
        c0 = rd_cnt[0];
        for (int i = 0; i < 18; i++) send(0, 8'h80 + 8'(i));
        chk("fill_level", 32'(level[0]),      32'd16);
        chk("fill_ovf",   32'(ovf[0]),        32'd1);
        chk("fill_rdcnt", 32'(rd_cnt[0] - c0), 32'd18);
        for (int i = 0; i < 16; i++) begin
            pop(0, d);
            chk("fill_data", 32'(d), 32'h80 + 32'(i));
        end
        chk("fill_empty", 32'(mvalid[0]), 32'd0);

        // Simultaneous push and pop at level 5
        for (int i = 0; i < 5; i++) send(0, 8'hA0 + 8'(i));
        @(negedge clk);
        valid[0] = 1'b1; rxd[0] = 8'hA5; ready[0] = 1'b1;
        d = mdata[0];
        @(negedge clk);
        ready[0] = 1'b0; valid[0] = 1'b0;
        chk("pp_popped", 32'(d),        32'hA0);
        chk("pp_level",  32'(level[0]), 32'd5);
        chk("pp_head",   32'(mdata[0]), 32'hA1);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            pop(0, d);
            chk("pp_drain", 32'(d), 32'hA1 + 32'(i));
        end

        // Backpressure when full
        for (int i = 0; i < 16; i++) send(1, 8'h50 + 8'(i));
        chk("bp_level", 32'(level[1]), 32'd16);
        @(negedge clk);
        c0 = rd_cnt[1];
        valid[1] = 1'b1; rxd[1] = 8'h60;
        repeat (4) @(negedge clk);
        chk("bp_no_rd",  32'(rd_cnt[1] - c0), 32'd0);
        chk("bp_hold16", 32'(level[1]),       32'd16);
        chk("bp_ovf",    32'(ovf[1]),         32'd0);
        pop(1, d);
        chk("bp_pop",   32'(d),        32'h50);
        chk("bp_lvl15", 32'(level[1]), 32'd15);
        got = 1'b0;
        for (int i = 0; i < 2 && !got; i++) begin
            @(negedge clk);
            if (rd[1]) got = 1'b1;
        end
        chk("bp_accept", 32'(got),       32'd1);
        chk("bp_lvl16",  32'(level[1]),  32'd16);
        valid[1] = 1'b0;
        @(negedge clk);
        chk("bp_rdcnt", 32'(rd_cnt[1] - c0), 32'd1);
        for (int i = 0; i < 16; i++) begin
            pop(1, d);
            chk("bp_drain", 32'(d), (i == 15) ? 32'h60 : 32'h51 + 32'(i));
        end

        // Asynchronous reset during ACK; overflow is still set from the fill above
        @(negedge clk);
        valid[0] = 1'b1; rxd[0] = 8'h7E;
        @(negedge clk);
        chk("ar_rd_ack", 32'(rd[0]), 32'd1);
        #2 resetq = 1'b0;
        #1;
        chk("ar_rd",     32'(rd[0]),     32'd0);
        chk("ar_level",  32'(level[0]),  32'd0);
        chk("ar_mvalid", 32'(mvalid[0]), 32'd0);
        chk("ar_ovf",    32'(ovf[0]),    32'd0);
        @(negedge clk);
        c0 = rd_cnt[0];
        resetq = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (rd[0]) got = 1'b1;
        end
        valid[0] = 1'b0;
        chk("ar_reread", 32'(got), 32'd1);
        repeat (4) @(negedge clk);
        chk("ar_rdcnt", 32'(rd_cnt[0] - c0), 32'd1);
        chk("ar_lvl1",  32'(level[0]),       32'd1);
        chk("ar_data",  32'(mdata[0]),       32'h7E);
        pop(0, d);
        chk("ar_lvl0", 32'(level[0]), 32'd0);

        // Overflow clear
        for (int i = 0; i < 17; i++) send(0, 8'(i));
        chk("clr_ovf_set", 32'(ovf[0]), 32'd1);
        ovf_clr[0] = 1'b1;
        @(negedge clk);
        ovf_clr[0] = 1'b0;
        chk("clr_ovf",   32'(ovf[0]),   32'd0);
        chk("clr_level", 32'(level[0]), 32'd16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
